// File: rtl/laser_echo_tof.sv
// laser_echo_tof: receive-side time-of-flight measurement for the LiDAR datapath.
//
// Each laser shot is started by a rising edge on FIRE. The block then times the
// rising edges on the asynchronous ECHO comparator output, counting in CLK cycles.
// Echoes that arrive during a short blanking interval right after FIRE are
// ignored. At the end of the listen window the block reports either the first
// and last echo timestamps with an echo count, or a timeout.
//
// Ports:
//   CLK        in   system clock
//   RSTn       in   asynchronous active-low reset
//   EN         in   measurement enable; low aborts the shot and idles the block
//   FIRE       in   synchronous laser fire strobe; the rising edge starts a shot
//   ECHO       in   asynchronous comparator output; the rising edge is a return
//   TOF_FIRST  out  timestamp of the first accepted echo (CNT_W bits)
//   TOF_LAST   out  timestamp of the last accepted echo (CNT_W bits)
//   ECHO_CNT   out  accepted echoes, saturating at 3
//   VALID      out  one-cycle pulse: results updated, at least one echo
//   TIMEOUT    out  one-cycle pulse: window closed with no echo
//   BUSY       out  high while blanking or listening
//
// FIRE is delayed through the same number of flops as the ECHO synchronizer,
// followed by the same edge detector, so both edges reach the FSM with equal
// latency. The reported timestamp is therefore the pin-level cycle distance
// from the FIRE rise to the ECHO rise.

module laser_echo_tof #(
  parameter int CNT_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 20,
  parameter int MAX_CYCLES   = 10000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             FIRE,
  input  logic             ECHO,
  output logic [CNT_W-1:0] TOF_FIRST,
  output logic [CNT_W-1:0] TOF_LAST,
  output logic [1:0]       ECHO_CNT,
  output logic             VALID,
  output logic             TIMEOUT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    LISTEN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_END = CNT_W'(MAX_CYCLES - 1);

  logic [SYNC_STAGES-1:0] echo_sync;
  logic [SYNC_STAGES-1:0] fire_dly;
  logic                   echo_prev;
  logic                   fire_prev;
  logic                   echo_edge;
  logic                   fire_edge;
  logic                   start_shot;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] first_cap;
  logic [CNT_W-1:0] last_cap;
  logic [1:0]       n_cap;

  // Input alignment: synchronizer / delay line plus edge-detect register.
  // NOTE: the synchronizer and delay flops are reset as well, so the first edge
  // detect after reset compares against a known 0 rather than a stale level.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      echo_sync <= '0;
      fire_dly  <= '0;
      echo_prev <= 1'b0;
      fire_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value its
      // predecessor held before this edge, which is what a shift chain needs.
      echo_sync <= {echo_sync[SYNC_STAGES-2:0], ECHO};
      fire_dly  <= {fire_dly[SYNC_STAGES-2:0], FIRE};
      echo_prev <= echo_sync[SYNC_STAGES-1];
      fire_prev <= fire_dly[SYNC_STAGES-1];
    end
  end

  assign echo_edge = echo_sync[SYNC_STAGES-1] & ~echo_prev;
  assign fire_edge = fire_dly[SYNC_STAGES-1] & ~fire_prev;

  // A shot may start from IDLE or straight out of the DONE cycle.
  assign start_shot = fire_edge & ((state == IDLE) | (state == DONE));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      first_cap <= '0;
      last_cap  <= '0;
      n_cap     <= '0;
      TOF_FIRST <= '0;
      TOF_LAST  <= '0;
      ECHO_CNT  <= '0;
      VALID     <= 1'b0;
      TIMEOUT   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      VALID   <= 1'b0;
      TIMEOUT <= 1'b0;
      if (!EN) begin
        // Abort: no result pulse, published results are kept.
        state <= IDLE;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_END) state <= LISTEN;
          end
          LISTEN: begin
            cnt <= cnt + 1'b1;
            if (echo_edge) begin
              if (n_cap == 2'd0) first_cap <= cnt;
              last_cap <= cnt;
              if (n_cap != 2'd3) n_cap <= n_cap + 2'd1;
            end
            // An echo edge in this final cycle is still captured above.
            if (cnt == WINDOW_END) begin
              state <= DONE;
              BUSY  <= 1'b0;
            end
          end
          DONE: begin
            if (n_cap != 2'd0) begin
              TOF_FIRST <= first_cap;
              TOF_LAST  <= last_cap;
              ECHO_CNT  <= n_cap;
              VALID     <= 1'b1;
            end else begin
              TOF_FIRST <= '0;
              TOF_LAST  <= '0;
              ECHO_CNT  <= '0;
              TIMEOUT   <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase

        if (start_shot) begin
          // The fire-detect cycle itself is count 0, so the first BLANK cycle
          // already reads 1 and echo timestamps equal the pin-level distance.
          state     <= BLANK;
          BUSY      <= 1'b1;
          cnt       <= CNT_W'(1);
          first_cap <= '0;
          last_cap  <= '0;
          n_cap     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_laser_echo_tof.sv
// tb_laser_echo_tof: self-checking bench for laser_echo_tof.
//
// A behavioural model tracks each shot by the absolute cycle of its FIRE rise and
// classifies every ECHO rise by its distance from that fire. A compare process
// checks all DUT outputs against the model on every falling clock edge. Directed
// shots pin the model with hand-computed results; a randomized phase follows.
// The listen window is shortened to keep run time small.

module tb_laser_echo_tof;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int BLANK = 20;
  localparam int MAX   = 1000;
  // Edge (relative to the FIRE sample edge) after which VALID/TIMEOUT is visible.
  localparam int LAT   = MAX + SYNC;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b1;
  logic             fire  = 1'b0;
  logic             echo  = 1'b0;
  logic [CNT_W-1:0] tof_first;
  logic [CNT_W-1:0] tof_last;
  logic [1:0]       echo_cnt;
  logic             valid;
  logic             timeout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  laser_echo_tof #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC),
    .BLANK_CYCLES(BLANK),
    .MAX_CYCLES  (MAX)
  ) dut (
    .CLK      (clk),
    .RSTn     (rst_n),
    .EN       (en),
    .FIRE     (fire),
    .ECHO     (echo),
    .TOF_FIRST(tof_first),
    .TOF_LAST (tof_last),
    .ECHO_CNT (echo_cnt),
    .VALID    (valid),
    .TIMEOUT  (timeout),
    .BUSY     (busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hf/he hold pin samples: index i is the sample taken i edges ago.
  bit [SYNC+1:0] hf = '0;
  bit [SYNC+1:0] he = '0;
  int  m_t = 0;        // edge counter
  int  m_p = 0;        // edge at which the active shot's FIRE rise was sampled
  int  m_n = 0;
  int  m_first = 0;
  int  m_last = 0;
  int  m_d = 0;
  bit  m_active = 0;
  bit  m_fr, m_er;
  int  x_first = 0, x_last = 0, x_cnt = 0;
  bit  x_valid = 0, x_timeout = 0, x_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hf = '0; he = '0; m_t = 0; m_active = 0; m_n = 0;
      x_first = 0; x_last = 0; x_cnt = 0;
      x_valid = 0; x_timeout = 0; x_busy = 0;
    end else begin
      m_t++;
      hf = {hf[SYNC:0], fire};
      he = {he[SYNC:0], echo};
      // Rises sampled SYNC edges ago are acted on now.
      m_fr = hf[SYNC] & ~hf[SYNC+1];
      m_er = he[SYNC] & ~he[SYNC+1];
      x_valid = 0;
      x_timeout = 0;
      if (m_active) begin
        if (!en) begin
          m_active = 0;
        end else begin
          if (m_er) begin
            m_d = (m_t - SYNC) - m_p;
            if (m_d >= BLANK && m_d <= MAX - 1) begin
              if (m_n == 0) m_first = m_d;
              m_last = m_d;
              if (m_n < 3) m_n++;
            end
          end
          if (m_t == m_p + LAT) begin
            if (m_n > 0) begin
              x_first = m_first; x_last = m_last; x_cnt = m_n; x_valid = 1;
            end else begin
              x_first = 0; x_last = 0; x_cnt = 0; x_timeout = 1;
            end
            m_active = 0;
          end
        end
      end
      if (!m_active && en && m_fr) begin
        m_active = 1;
        m_p = m_t - SYNC;
        m_n = 0;
      end
      x_busy = m_active && (m_t < m_p + LAT - 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("valid", valid, x_valid);
    check("timeout", timeout, x_timeout);
    check("busy", busy, x_busy);
    check("tof_first", tof_first, x_first);
    check("tof_last", tof_last, x_last);
    check("echo_cnt", echo_cnt, x_cnt);
  end

  // ---------------- directed shots ----------------
  int hold_first = 0, hold_last = 0, hold_cnt = 0;

  // Echo offsets of -1 are unused; fire2/en_drop/rst_at of -1 are unused.
  // exp_kind: 0 no pulse, 1 VALID, 2 TIMEOUT.
  task automatic shot(input string name, input int o0, input int o1, input int o2,
                      input int o3, input int fire2, input int en_drop,
                      input int rst_at, input int exp_kind, input int exp_first,
                      input int exp_last, input int exp_cnt, input int exp_busy_end);
    int offs[4] = '{o0, o1, o2, o3};
    int pulses = 0;
    int pulse_at = -1;
    int kind = 0;
    for (int k = 0; k <= LAT + 3; k++) begin
      @(negedge clk);
      // Outputs now reflect edge k-1 of this shot.
      if (k > 0 && (valid || timeout)) begin
        pulses++;
        pulse_at = k - 1;
        kind = valid ? 1 : 2;
      end
      if (en_drop >= 0 && k == en_drop + 1) check({name, " busy after abort"}, busy, 0);
      if (k == rst_at + 1) rst_n = 1'b1;
      fire = (k == 0) || (k == fire2);
      echo = 1'b0;
      foreach (offs[i])
        if (offs[i] >= 0 && k >= offs[i] && k < offs[i] + 3) echo = 1'b1;
      en = (k != en_drop);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check({name, " rst valid"}, valid, 0);
        check({name, " rst timeout"}, timeout, 0);
        check({name, " rst busy"}, busy, 0);
        check({name, " rst tof_first"}, tof_first, 0);
        check({name, " rst tof_last"}, tof_last, 0);
        check({name, " rst echo_cnt"}, echo_cnt, 0);
      end
    end
    check({name, " pulse count"}, pulses, (exp_kind != 0) ? 1 : 0);
    if (exp_kind != 0) begin
      check({name, " pulse kind"}, kind, exp_kind);
      check({name, " pulse edge"}, pulse_at, LAT);
    end
    if (exp_kind == 1) begin
      hold_first = exp_first; hold_last = exp_last; hold_cnt = exp_cnt;
    end else if (exp_kind == 2 || rst_at >= 0) begin
      hold_first = 0; hold_last = 0; hold_cnt = 0;
    end
    check({name, " tof_first"}, tof_first, hold_first);
    check({name, " tof_last"}, tof_last, hold_last);
    check({name, " echo_cnt"}, echo_cnt, hold_cnt);
    check({name, " busy at end"}, busy, exp_busy_end);
  endtask

  // ---------------- stimulus ----------------
  int echo_left = 0;
  int echo_rate = 80;

  initial begin
    repeat (3) @(negedge clk);
    check("reset valid", valid, 0);
    check("reset timeout", timeout, 0);
    check("reset busy", busy, 0);
    check("reset tof_first", tof_first, 0);
    check("reset tof_last", tof_last, 0);
    check("reset echo_cnt", echo_cnt, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    shot("single",      500,  -1,  -1,  -1,  -1, -1,  -1, 1, 500, 500, 1, 0);
    shot("multi",       100, 300, 700, 900,  -1, -1,  -1, 1, 100, 900, 3, 0);
    shot("blank19",      19,  -1,  -1,  -1,  -1, -1,  -1, 2,   0,   0, 0, 0);
    shot("blank20",      20,  -1,  -1,  -1,  -1, -1,  -1, 1,  20,  20, 1, 0);
    shot("win_last",    999,  -1,  -1,  -1,  -1, -1,  -1, 1, 999, 999, 1, 0);
    shot("win_past",   1000,  -1,  -1,  -1,  -1, -1,  -1, 2,   0,   0, 0, 0);
    shot("overlap",     150, 600,  -1,  -1, 200, -1,  -1, 1, 150, 600, 2, 0);
    shot("en_abort",    400,  -1,  -1,  -1,  -1, 50,  -1, 0,   0,   0, 0, 0);
    shot("multi2",       30,  60,  -1,  -1,  -1, -1,  -1, 1,  30,  60, 2, 0);
    shot("rst_mid",     100,  -1,  -1,  -1,  -1, -1, 300, 0,   0,   0, 0, 0);
    shot("after_rst",   250,  -1,  -1,  -1,  -1, -1,  -1, 1, 250, 250, 1, 0);
    // Second fire lands in the DONE cycle and restarts immediately.
    shot("done_restart", 40,  -1,  -1,  -1, MAX, -1,  -1, 1,  40,  40, 1, 1);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (i == 15000) echo_rate = 1500;
      rst_n = 1'b1;
      fire = ($urandom_range(0, 299) == 0);
      if (echo_left > 0) begin
        echo = 1'b1;
        echo_left--;
      end else if (echo) begin
        echo = 1'b0;
      end else if ($urandom_range(0, echo_rate - 1) == 0) begin
        echo = 1'b1;
        echo_left = $urandom_range(0, 3);
      end
      if (!en) en = ($urandom_range(0, 2) == 0);
      else     en = ($urandom_range(0, 2999) != 0);
      if (i == 22222) #2 rst_n = 1'b0;
    end
    en = 1'b1;
    fire = 1'b0;
    echo = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
